// File: rtl/axis_frame_fifo_pkg.sv
// axis_frame_fifo_pkg: shared types for the store-and-forward frame FIFO
package axis_frame_fifo_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_STORE, ST_DROP} wr_state_e;
endpackage

// File: rtl/axis_if.sv
// AXIS_IF: AXI-Stream bundle with transmitter/receiver views
interface AXIS_IF #(
  parameter int DATA_WIDTH  = 8,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  logic                   tvalid;
  logic                   tready;
  logic [DATA_WIDTH-1:0]  tdata;
  logic [KEEP_WIDTH-1:0]  tkeep;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   twakeup;
  modport Transmitter (output tvalid, tdata, tkeep, tlast, tid, tdest, tuser, twakeup, input tready);
  modport Receiver (input tvalid, tdata, tkeep, tlast, tid, tdest, tuser, twakeup, output tready);
endinterface

// File: rtl/axis_frame_fifo_sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port
module sdp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  assign rdata = rdata_q;
endmodule

// File: rtl/axis_frame_fifo.sv
// axis_frame_fifo: store-and-forward AXIS frame FIFO dropping bad and overflowing frames
module axis_frame_fifo
  import axis_frame_fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 2048,
  parameter int DROP_BAD_FRAME = 1,
  parameter int USER_BAD_BIT   = 0
) (
  input  logic         clk,
  input  logic         rst,
  AXIS_IF.Receiver     s_axis,
  AXIS_IF.Transmitter  m_axis,
  output logic         good_frame,
  output logic         bad_frame,
  output logic         overflow
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = DATA_WIDTH + KW + 1;
  wr_state_e state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
  logic tvalid_q, tvalid_d, good_q, good_d, bad_q, bad_d, ovf_q, ovf_d;
  logic we, re, full, empty, is_bad, unused_ok;
  logic [RW-1:0] rd_data;
  assign full   = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign empty  = rd_ptr_q == wr_commit_q;
  assign is_bad = (DROP_BAD_FRAME != 0) && s_axis.tuser[USER_BAD_BIT];
  assign re     = !empty && (!tvalid_q || m_axis.tready);
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    good_d      = 1'b0;
    bad_d       = 1'b0;
    ovf_d       = 1'b0;
    we          = 1'b0;
    if (s_axis.tvalid) begin
      if (state_q == ST_DROP) state_d = s_axis.tlast ? ST_IDLE : ST_DROP;
      else if (full) begin
        wr_ptr_d = wr_commit_q;
        ovf_d    = 1'b1;
        state_d  = s_axis.tlast ? ST_IDLE : ST_DROP;
      end else begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        state_d  = s_axis.tlast ? ST_IDLE : ST_STORE;
        if (s_axis.tlast && is_bad) begin
          wr_ptr_d = wr_commit_q;
          bad_d    = 1'b1;
        end else if (s_axis.tlast) begin
          wr_commit_d = wr_ptr_q + 1'b1;
          good_d      = 1'b1;
        end
      end
    end
    rd_ptr_d = rd_ptr_q + PW'(re);
    tvalid_d = re || (tvalid_q && !m_axis.tready);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      tvalid_q    <= 1'b0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      tvalid_q    <= tvalid_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      ovf_q       <= ovf_d;
    end
  // the RAM output register doubles as the m_axis payload register
  sdp_ram #(.WIDTH(RW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({s_axis.tlast, s_axis.tkeep, s_axis.tdata}),
    .re    (re),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );
  assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = rd_data;
  assign m_axis.tvalid  = tvalid_q;
  assign m_axis.tid     = '0;
  assign m_axis.tdest   = '0;
  assign m_axis.tuser   = '0;
  assign m_axis.twakeup = 1'b0;
  assign s_axis.tready  = !rst;
  assign good_frame     = good_q;
  assign bad_frame      = bad_q;
  assign overflow       = ovf_q;
  assign unused_ok      = ^{s_axis.tid, s_axis.tdest, s_axis.tuser, s_axis.twakeup};
endmodule
